stitch_sb_slot_alloc: RTL and testbench

//  Scoreboard slot allocator between FPU issue and the one-hot slot free-list pool.

---
 rtl/stitch_sb_pkg.sv | 30 +++
 rtl/stitch_sb_hazard_check.sv | 29 ++
 rtl/stitch_sb_slot_alloc.sv | 85 ++++++++
 tb/tb_stitch_sb_slot_alloc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stitch_sb_pkg.sv
// Shared types for the FPU scoreboard slot allocator: one-hot slot tags, slot entries,
// and the tag-to-index helper.
package stitch_sb_pkg;

  localparam int unsigned NumSlots     = 8;
  localparam int unsigned NumRegs      = 32;
  localparam int unsigned RegAddrWidth = $clog2(NumRegs);
  localparam int unsigned SlotIdxWidth = $clog2(NumSlots);
  localparam int unsigned NumRs        = 3;

  typedef logic [NumSlots-1:0]     slot_tag_t;
  typedef logic [RegAddrWidth-1:0] reg_addr_t;
  typedef logic [SlotIdxWidth-1:0] slot_idx_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
  } slot_entry_t;

  // Callers guarantee a one-hot tag. Any other input gives the OR of the set indices.
  function automatic slot_idx_t onehot2bin(slot_tag_t tag);
    slot_idx_t idx;
    idx = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (tag[i]) idx = idx | slot_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/stitch_sb_hazard_check.sv
// RAW/WAW detection of one issuing instruction against the in-flight slot table.
// Slots named in wb_mask_i are treated as already retired.
module stitch_sb_hazard_check
  import stitch_sb_pkg::*;
(
  input  slot_entry_t [NumSlots-1:0] slots_i,
  input  slot_tag_t                  wb_mask_i,
  input  reg_addr_t   [NumRs-1:0]    rs_i,
  input  logic        [NumRs-1:0]    rs_en_i,
  input  logic                       has_rd_i,
  input  reg_addr_t                  rd_i,
  output logic                       raw_o,
  output logic                       waw_o
);

  always_comb begin
    raw_o = 1'b0;
    waw_o = 1'b0;
    for (int s = 0; s < NumSlots; s++) begin
      if (slots_i[s].valid && !wb_mask_i[s]) begin
        for (int k = 0; k < NumRs; k++) begin
          if (rs_en_i[k] && (rs_i[k] == slots_i[s].rd)) raw_o = 1'b1;
        end
        if (has_rd_i && (rd_i == slots_i[s].rd)) waw_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stitch_sb_slot_alloc.sv
// Scoreboard slot allocator: pops a one-hot tag per rd-writing issue, tracks slot -> rd,
// stalls RAW/WAW hazards, and returns tags on writeback. STITCH_SB_WB_BYPASS_EN lets a
// legal writeback clear its hazard in the same cycle.
module stitch_sb_slot_alloc
  import stitch_sb_pkg::*;
(
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                issue_valid_i,
  output logic                                issue_ready_o,
  input  logic                                issue_has_rd_i,
  input  logic [RegAddrWidth-1:0]             issue_rd_i,
  input  logic [NumRs-1:0][RegAddrWidth-1:0]  issue_rs_i,
  input  logic [NumRs-1:0]                    issue_rs_en_i,
  output logic [NumSlots-1:0]                 issue_tag_o,
  input  logic                                pool_empty_i,
  input  logic [NumSlots-1:0]                 pool_data_i,
  output logic                                pool_pop_o,
  output logic                                pool_push_o,
  output logic [NumSlots-1:0]                 pool_data_o,
  input  logic                                wb_valid_i,
  input  logic [NumSlots-1:0]                 wb_tag_i,
  output logic [NumSlots-1:0]                 busy_o,
  output logic [NumRegs-1:0]                  reg_busy_o,
  output logic                                err_o
);

  slot_entry_t [NumSlots-1:0] slot_q, slot_d;
  slot_tag_t                  wb_mask;
  logic                       wb_legal, raw, waw, alloc;

  always_comb begin
    wb_legal = wb_valid_i && $onehot(wb_tag_i) && slot_q[onehot2bin(wb_tag_i)].valid;
  end

`ifdef STITCH_SB_WB_BYPASS_EN
  assign wb_mask = wb_legal ? wb_tag_i : '0;
`else
  assign wb_mask = '0;
`endif

  stitch_sb_hazard_check u_hazard (
    .slots_i   (slot_q),
    .wb_mask_i (wb_mask),
    .rs_i      (issue_rs_i),
    .rs_en_i   (issue_rs_en_i),
    .has_rd_i  (issue_has_rd_i),
    .rd_i      (issue_rd_i),
    .raw_o     (raw),
    .waw_o     (waw)
  );

  assign issue_ready_o = !(raw || waw) && !(issue_has_rd_i && pool_empty_i);
  assign alloc         = issue_valid_i && issue_ready_o && issue_has_rd_i;
  assign pool_pop_o    = alloc;
  assign issue_tag_o   = alloc ? pool_data_i : '0;
  assign pool_push_o   = wb_legal;
  assign pool_data_o   = wb_tag_i;
  assign err_o         = wb_valid_i && !wb_legal;

  always_comb begin
    busy_o     = '0;
    reg_busy_o = '0;
    for (int s = 0; s < NumSlots; s++) begin
      busy_o[s] = slot_q[s].valid;
      if (slot_q[s].valid) reg_busy_o[slot_q[s].rd] = 1'b1;
    end
  end

  // Allocation is applied after the clear so a passed-through tag ends up valid.
  always_comb begin
    slot_d = slot_q;
    if (wb_legal) slot_d[onehot2bin(wb_tag_i)].valid = 1'b0;
    if (alloc)    slot_d[onehot2bin(pool_data_i)] = slot_entry_t'{valid: 1'b1, rd: issue_rd_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) slot_q <= '0;
    else         slot_q <= slot_d;
  end

  pop_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pool_pop_o |-> $onehot(pool_data_i));

endmodule

// File: tb/tb_stitch_sb_slot_alloc.sv
// Self-checking bench: FIFO pool model plus a slot/register reference model checked every cycle,
// with directed scenarios pinned by literal expectations and a randomized phase.
module tb_stitch_sb_slot_alloc;
  import stitch_sb_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                               issue_valid_i, issue_ready_o, issue_has_rd_i;
  logic [RegAddrWidth-1:0]            issue_rd_i;
  logic [NumRs-1:0][RegAddrWidth-1:0] issue_rs_i;
  logic [NumRs-1:0]                   issue_rs_en_i;
  logic [NumSlots-1:0]                issue_tag_o, pool_data_i, pool_data_o, wb_tag_i, busy_o;
  logic                               pool_empty_i, pool_pop_o, pool_push_o, wb_valid_i, err_o;
  logic [NumRegs-1:0]                 reg_busy_o;

  stitch_sb_slot_alloc dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_has_rd_i(issue_has_rd_i), .issue_rd_i(issue_rd_i),
    .issue_rs_i(issue_rs_i), .issue_rs_en_i(issue_rs_en_i), .issue_tag_o(issue_tag_o),
    .pool_empty_i(pool_empty_i), .pool_data_i(pool_data_i), .pool_pop_o(pool_pop_o),
    .pool_push_o(pool_push_o), .pool_data_o(pool_data_o),
    .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i),
    .busy_o(busy_o), .reg_busy_o(reg_busy_o), .err_o(err_o)
  );

`ifdef STITCH_SB_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  // Reference model: which slots are in flight and which register each one will write
  bit        m_valid [NumSlots];
  int        m_rd    [NumSlots];
  slot_tag_t pool_q  [$];

  // Stimulus for the next cycle
  bit        s_valid, s_has_rd, s_wb_valid, force_empty;
  int        s_rd;
  int        s_rs [NumRs];
  bit [2:0]  s_rs_en;
  slot_tag_t s_wb_tag;

  // Outputs sampled during the last step
  logic [31:0] a_ready, a_tag, a_pop, a_push, a_err, a_busy, a_regbusy;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NumSlots; i++) m_valid[i] = 1'b0;
    pool_q.delete();
    for (int i = 0; i < NumSlots; i++) pool_q.push_back(slot_tag_t'(1 << i));
  endfunction

  function automatic void set_idle();
    s_valid = 0; s_has_rd = 0; s_rd = 0; s_rs_en = '0; s_wb_valid = 0; s_wb_tag = '0;
    force_empty = 0;
    for (int k = 0; k < NumRs; k++) s_rs[k] = 0;
  endfunction

  function automatic int tag_index(slot_tag_t t);
    int idx = -1;
    for (int i = 0; i < NumSlots; i++) if (t[i]) idx = i;
    return idx;
  endfunction

  // Drive one cycle of stimulus, check all outputs against the model, then advance both.
  task automatic step();
    bit          legal, hazard, e_ready, e_pop;
    int          wi, skip, pi;
    logic [31:0] regs, e_busy;
    logic        dut_pop, dut_push;
    slot_tag_t   dut_push_tag;
    @(negedge clk_i);
    issue_valid_i  = s_valid;
    issue_has_rd_i = s_has_rd;
    issue_rd_i     = reg_addr_t'(s_rd);
    for (int k = 0; k < NumRs; k++) issue_rs_i[k] = reg_addr_t'(s_rs[k]);
    issue_rs_en_i  = s_rs_en;
    wb_valid_i     = s_wb_valid;
    wb_tag_i       = s_wb_tag;
    pool_empty_i   = force_empty || (pool_q.size() == 0);
    pool_data_i    = pool_empty_i ? '0 : pool_q[0];
    #2;
    wi    = tag_index(s_wb_tag);
    legal = s_wb_valid && ($countones(s_wb_tag) == 1) && m_valid[wi];
    skip  = (Bypass && legal) ? wi : -1;
    regs = '0; e_busy = '0;
    for (int i = 0; i < NumSlots; i++) if (m_valid[i]) begin
      e_busy[i] = 1'b1;
      if (i != skip) regs[m_rd[i]] = 1'b1;
    end
    hazard = s_has_rd && regs[s_rd];
    for (int k = 0; k < NumRs; k++) if (s_rs_en[k] && regs[s_rs[k]]) hazard = 1;
    e_ready = !hazard && !(s_has_rd && pool_empty_i);
    e_pop   = s_valid && e_ready && s_has_rd;
    // reg_busy is always from registered state, independent of bypass
    regs = '0;
    for (int i = 0; i < NumSlots; i++) if (m_valid[i]) regs[m_rd[i]] = 1'b1;

    chk("issue_ready", 32'(issue_ready_o), 32'(e_ready));
    chk("pool_pop",    32'(pool_pop_o),    32'(e_pop));
    chk("issue_tag",   32'(issue_tag_o),   e_pop ? 32'(pool_data_i) : 32'h0);
    chk("pool_push",   32'(pool_push_o),   32'(legal));
    if (legal) chk("pool_data_o", 32'(pool_data_o), 32'(s_wb_tag));
    chk("err",         32'(err_o),         32'(s_wb_valid && !legal));
    chk("busy",        32'(busy_o),        e_busy);
    chk("reg_busy",    reg_busy_o,         regs);

    a_ready = 32'(issue_ready_o); a_tag = 32'(issue_tag_o); a_pop = 32'(pool_pop_o);
    a_push = 32'(pool_push_o); a_err = 32'(err_o); a_busy = 32'(busy_o); a_regbusy = reg_busy_o;
    dut_pop = pool_pop_o; dut_push = pool_push_o; dut_push_tag = pool_data_o;
    pi = tag_index(pool_data_i);

    @(posedge clk_i);
    if (legal) m_valid[wi] = 1'b0;
    if (e_pop) begin m_valid[pi] = 1'b1; m_rd[pi] = s_rd; end
    if (dut_pop && pool_q.size() > 0) void'(pool_q.pop_front());
    if (dut_push && $countones(dut_push_tag) == 1 && pool_q.size() < NumSlots)
      pool_q.push_back(dut_push_tag);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1 model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    set_idle();
    issue_valid_i = 0; issue_has_rd_i = 0; issue_rd_i = '0; issue_rs_i = '0;
    issue_rs_en_i = '0; wb_valid_i = 0; wb_tag_i = '0; pool_empty_i = 0;
    pool_data_i = 8'h01;
    model_reset();
    #12;
    chk("reset_busy",     32'(busy_o),        32'h0);
    chk("reset_reg_busy", reg_busy_o,         32'h0);
    chk("reset_err",      32'(err_o),         32'h0);
    chk("reset_pop",      32'(pool_pop_o),    32'h0);
    chk("reset_push",     32'(pool_push_o),   32'h0);
    chk("reset_tag",      32'(issue_tag_o),   32'h0);
    chk("reset_ready",    32'(issue_ready_o), 32'h1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill all eight slots in pool order, then the ninth stalls on an empty pool
    for (int i = 0; i < NumSlots; i++) begin
      set_idle(); s_valid = 1; s_has_rd = 1; s_rd = i;
      step();
      chk("t1_tag", a_tag, 32'(1 << i));
    end
    set_idle(); s_valid = 1; s_has_rd = 1; s_rd = 8;
    step();
    chk("t1_ninth_ready", a_ready, 32'h0);
    chk("t1_busy_full", a_busy, 32'hFF);
    chk("t1_regbusy", a_regbusy, 32'hFF);
    for (int i = 0; i < NumSlots; i++) begin
      set_idle(); s_wb_valid = 1; s_wb_tag = slot_tag_t'(1 << i);
      step();
    end

    // RAW stall on rd=3 until its writeback
    set_idle(); s_valid = 1; s_has_rd = 1; s_rd = 3;
    step();
    chk("t2_tag", a_tag, 32'h01);
    s_rd = 10; s_rs[0] = 3; s_rs_en = 3'b001;
    step(); chk("t2_stall0", a_ready, 32'h0);
    step(); chk("t2_stall1", a_ready, 32'h0);
    s_wb_valid = 1; s_wb_tag = 8'h01;
    step(); chk("t2_wb_cycle_ready", a_ready, Bypass ? 32'h1 : 32'h0);
    s_wb_valid = 0; s_wb_tag = '0;
    if (!Bypass) begin
      step(); chk("t2_after_wb_ready", a_ready, 32'h1);
    end
    set_idle(); s_wb_valid = 1; s_wb_tag = 8'h02;
    step(); chk("t2_drain_push", a_push, 32'h1);

    // No-rd issue proceeds with an empty pool and never pops
    set_idle(); force_empty = 1; s_valid = 1; s_has_rd = 0;
    step();
    chk("t3_ready", a_ready, 32'h1);
    chk("t3_pop", a_pop, 32'h0);
    chk("t3_tag", a_tag, 32'h0);

    // Illegal writebacks: idle slot, then non-one-hot tag
    set_idle(); s_wb_valid = 1; s_wb_tag = 8'h04;
    step(); chk("t4_err_idle", a_err, 32'h1); chk("t4_push_idle", a_push, 32'h0);
    s_wb_tag = 8'h06;
    step(); chk("t4_err_multi", a_err, 32'h1); chk("t4_push_multi", a_push, 32'h0);
    set_idle();
    step(); chk("t4_err_clear", a_err, 32'h0);

    // Asynchronous reset with busy_o = 0x3C
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_idle(); s_valid = 1; s_has_rd = 1; s_rd = i;
      step();
    end
    set_idle(); s_wb_valid = 1; s_wb_tag = 8'h01; step();
    s_wb_tag = 8'h02; step();
    set_idle(); step();
    chk("t6_busy_pre", a_busy, 32'h3C);
    chk("t6_regbusy_pre", a_regbusy, 32'h3C);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("t6_busy_async", 32'(busy_o), 32'h0);
    chk("t6_regbusy_async", reg_busy_o, 32'h0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Writeback of slot 0 (rd=5) together with a new rd=5 issue
    set_idle(); s_valid = 1; s_has_rd = 1; s_rd = 5;
    step(); chk("t5_first_tag", a_tag, 32'h01);
    s_wb_valid = 1; s_wb_tag = 8'h01;
    step(); chk("t5_wb_cycle_ready", a_ready, Bypass ? 32'h1 : 32'h0);
    s_wb_valid = 0; s_wb_tag = '0;
    if (Bypass) chk("t5_bypass_tag", a_tag, 32'h02);
    else begin
      step(); chk("t5_retry_ready", a_ready, 32'h1);
    end
    set_idle(); step();
    chk("t5_regbusy", a_regbusy, 32'h20);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int live [$];
      set_idle();
      s_valid  = ($urandom_range(3) != 0);
      s_has_rd = ($urandom_range(3) != 0);
      s_rd     = ($urandom_range(7) == 0) ? int'($urandom_range(31)) : int'($urandom_range(7));
      for (int k = 0; k < NumRs; k++) s_rs[k] = int'($urandom_range(9));
      s_rs_en  = 3'($urandom_range(7));
      for (int i = 0; i < NumSlots; i++) if (m_valid[i]) live.push_back(i);
      case ($urandom_range(9))
        0, 1, 2, 3, 4: if (live.size() > 0) begin
          s_wb_valid = 1;
          s_wb_tag   = slot_tag_t'(1 << live[$urandom_range(live.size() - 1)]);
        end
        5: begin s_wb_valid = 1; s_wb_tag = slot_tag_t'($urandom_range(255)); end
        default: ;
      endcase
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
